sine_wave_gen: RTL and testbench

//  Direct digital synthesis (DDS) sine source. A phase accumulator advances by

---
 rtl/sine_wave_pkg.sv | 41 ++++
 rtl/sine_wave_gen_if.sv | 19 +
 rtl/sine_quarter_rom.sv | 35 +++
 rtl/sine_wave_gen.sv | 83 ++++++++
 tb/tb_sine_wave_gen.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sine_wave_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sine_wave_pkg
// Description : Shared definitions for the DDS sine source: quadrant encoding,
//               quarter-wave ROM sizing helpers and the elaboration-time
//               function that computes the quarter-wave magnitude table.
// Revision    : 1.0 - initial release
// ============================================================================
package sine_wave_pkg;

  // Top two phase bits select the quadrant of the sine period.
  typedef enum logic [1:0] {
    QUAD_RISE     = 2'd0,  // M + Q[a]
    QUAD_FALL     = 2'd1,  // M + Q[N-a]
    QUAD_NEG_FALL = 2'd2,  // M - Q[a]
    QUAD_NEG_RISE = 2'd3   // M - Q[N-a]
  } quadrant_e;

  localparam real PI = 3.14159265358979323846;

  // Number of quarter-wave steps N for a given phase width.
  function automatic int quarter_steps(input int phase_width);
    return 2 ** (phase_width - 2);
  endfunction

  // Peak amplitude A = M - 1, so the full-scale output never reaches 0.
  function automatic int amplitude(input int data_width);
    return 2 ** (data_width - 1) - 1;
  endfunction

  // Q[k] = round(A * sin(pi*k / (2N))), k in 0..N. The argument never
  // leaves the first quadrant, so the value is non-negative and a plain
  // +0.5 truncation is round-half-away-from-zero. Used only for constants.
  function automatic int quarter_sine(input int k, input int n, input int amp);
    real x;
    x = real'(amp) * $sin(PI * real'(k) / (2.0 * real'(n)));
    return $rtoi(x + 0.5);
  endfunction

endpackage : sine_wave_pkg
`default_nettype wire

// File: rtl/sine_wave_gen_if.sv
`default_nettype none
// ============================================================================
// Interface   : sine_wave_gen_if
// Description : Tuning-word input and sample output of the DDS sine source.
//   freq_control : phase increment per clock (driven by master)
//   sine_out     : registered offset-binary sine sample (driven by slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface sine_wave_gen_if #(
  parameter int PHASE_WIDTH = 10,
  parameter int DATA_WIDTH  = 8
);
  logic [PHASE_WIDTH-1:0] freq_control;
  logic [DATA_WIDTH-1:0]  sine_out;

  modport master (output freq_control, input sine_out);
  modport slave  (input freq_control, output sine_out);
endinterface : sine_wave_gen_if
`default_nettype wire

// File: rtl/sine_quarter_rom.sv
`default_nettype none
// ============================================================================
// Module      : sine_quarter_rom
// Description : Combinational quarter-wave sine magnitude lookup, N+1 entries
//               (index 0..N inclusive, Q[0]=0, Q[N]=A). Contents are computed
//               at elaboration from the package function.
//   index     in  PHASE_WIDTH-1  table index, valid range 0..N
//   magnitude out DATA_WIDTH-1   Q[index]
// Revision    : 1.0 - initial release
// ============================================================================
module sine_quarter_rom
  import sine_wave_pkg::*;
#(
  parameter int PHASE_WIDTH = 10,
  parameter int DATA_WIDTH  = 8
) (
  input  logic [PHASE_WIDTH-2:0] index,
  output logic [DATA_WIDTH-2:0]  magnitude
);

  localparam int STEPS = quarter_steps(PHASE_WIDTH);
  localparam int AMP   = amplitude(DATA_WIDTH);

  logic [DATA_WIDTH-2:0] rom [0:STEPS];

  for (genvar k = 0; k <= STEPS; k++) begin : g_rom
    localparam int QVAL = quarter_sine(k, STEPS, AMP);
    assign rom[k] = QVAL[DATA_WIDTH-2:0];
  end

  // The top never presents an index above N (mirror of a=0 gives exactly N).
  assign magnitude = rom[index];

endmodule : sine_quarter_rom
`default_nettype wire

// File: rtl/sine_wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : sine_wave_gen
// Description : Direct digital synthesis sine source. A phase accumulator
//               advances by freq_control every clock; its value addresses a
//               quarter-wave ROM whose output is unfolded by quadrant symmetry
//               into an unsigned offset-binary sample.
//               f_out = f_clk * freq_control / 2**PHASE_WIDTH.
//   clk        in  1   system clock, rising edge
//   reset      in  1   asynchronous active-low reset
//   bus        slave   freq_control (in), sine_out (out, registered)
// Revision    : 1.0 - initial release
// ============================================================================
module sine_wave_gen
  import sine_wave_pkg::*;
#(
  parameter int PHASE_WIDTH = 10,
  parameter int DATA_WIDTH  = 8
) (
  input  logic            clk,
  input  logic            reset,
  sine_wave_gen_if.slave  bus
);

  if (PHASE_WIDTH < 4 || DATA_WIDTH < 2) begin : g_param_check
    $error("sine_wave_gen: PHASE_WIDTH must be >= 4 and DATA_WIDTH >= 2");
  end

  localparam logic [PHASE_WIDTH-2:0] QUARTER_IDX = (PHASE_WIDTH-1)'(quarter_steps(PHASE_WIDTH));
  localparam logic [DATA_WIDTH-1:0]  MIDSCALE    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [PHASE_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0]  sample;
  logic [DATA_WIDTH-1:0]  sample_next;
  quadrant_e              quad;
  logic [PHASE_WIDTH-3:0] frac;
  logic [PHASE_WIDTH-2:0] rom_index;
  logic [DATA_WIDTH-2:0]  magnitude;

  assign quad = quadrant_e'(acc[PHASE_WIDTH-1:PHASE_WIDTH-2]);
  assign frac = acc[PHASE_WIDTH-3:0];

  // Falling quadrants read the table backwards; a=0 mirrors to index N,
  // which is why the table carries N+1 entries.
  always_comb begin
    rom_index = {1'b0, frac};
    if (quad == QUAD_FALL || quad == QUAD_NEG_RISE) begin
      rom_index = QUARTER_IDX - {1'b0, frac};
    end
  end

  sine_quarter_rom #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_rom (
    .index     (rom_index),
    .magnitude (magnitude)
  );

  // Negative half-period subtracts from midscale. Since Q never exceeds
  // M-1, the result stays within 1..2M-1 with no wrap.
  always_comb begin
    sample_next = MIDSCALE + {1'b0, magnitude};
    if (quad == QUAD_NEG_FALL || quad == QUAD_NEG_RISE) begin
      sample_next = MIDSCALE - {1'b0, magnitude};
    end
  end

  // Sample uses the pre-update phase, giving one cycle of acc->out latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      sample <= MIDSCALE;
    end else begin
      acc    <= acc + bus.freq_control;
      sample <= sample_next;
    end
  end

  assign bus.sine_out = sample;

endmodule : sine_wave_gen
`default_nettype wire

// File: tb/tb_sine_wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sine_wave_gen
// Description : Self-checking bench for sine_wave_gen. A phase model pushes
//               the golden sample S(p) for every clock edge into a queue;
//               after the edge the oldest entry is popped and compared with
//               sine_out. S(p) is evaluated directly over the full period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sine_wave_gen;

  localparam int PW     = 10;
  localparam int DW     = 8;
  localparam int PERIOD = 2 ** PW;
  localparam real TB_PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset;

  sine_wave_gen_if #(.PHASE_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

  sine_wave_gen #(.PHASE_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_acc = 0;
  int exp_q[$];
  int sweep[0:PERIOD-1];

  // S(p) = 128 + round(127*sin(2*pi*p/1024)), half away from zero.
  function automatic int golden(input int p);
    real x;
    int  r;
    x = 127.0 * $sin(2.0 * TB_PI * real'(p) / real'(PERIOD));
    if (x >= 0.0) r = $rtoi(x + 0.5);
    else          r = -$rtoi(-x + 0.5);
    return 128 + r;
  endfunction

  // Predict the next sample, advance the phase model, then let the edge happen.
  task automatic run_cycle();
    exp_q.push_back(golden(model_acc));
    model_acc = (model_acc + int'(bus.freq_control)) % PERIOD;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_acc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.freq_control = '0;
    model_reset();
    repeat (4) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.sine_out !== 8'd128) begin
        errors++;
        $display("FAIL reset_out: got %0d expected 128", bus.sine_out);
      end
      checks++;
      if (dut.acc !== 10'd0) begin
        errors++;
        $display("FAIL reset_acc: got %0d expected 0", dut.acc);
      end
    end
  endtask

  task automatic test_freeze();
    int exp;
    reset = 1'b1;
    bus.freq_control = 10'd0;
    repeat (16) begin
      run_cycle();
      exp = exp_q.pop_front();
      checks++;
      if (bus.sine_out !== 8'(exp) || bus.sine_out !== 8'd128) begin
        errors++;
        $display("FAIL freeze: got %0d expected %0d", bus.sine_out, exp);
      end
    end
  endtask

  task automatic test_quarter_step();
    int exp;
    int pattern[4];
    pattern = '{128, 255, 128, 1};
    bus.freq_control = 10'd256;
    for (int i = 0; i < 12; i++) begin
      run_cycle();
      exp = exp_q.pop_front();
      checks++;
      if (bus.sine_out !== 8'(exp) || exp != pattern[i % 4]) begin
        errors++;
        $display("FAIL quarter_step[%0d]: got %0d expected %0d", i, bus.sine_out, pattern[i % 4]);
      end
    end
  endtask

  task automatic test_golden_sweep();
    int exp;
    int phase;
    bus.freq_control = 10'd1;
    for (int i = 0; i < PERIOD; i++) begin
      phase = model_acc;
      run_cycle();
      exp = exp_q.pop_front();
      sweep[phase] = int'(bus.sine_out);
      checks++;
      if (bus.sine_out !== 8'(exp)) begin
        errors++;
        $display("FAIL sweep[p=%0d]: got %0d expected %0d", phase, bus.sine_out, exp);
      end
    end
    for (int p = 0; p < PERIOD / 2; p++) begin
      checks++;
      if (sweep[p] + sweep[p + PERIOD / 2] != 256) begin
        errors++;
        $display("FAIL odd_symmetry[p=%0d]: got sum %0d expected 256", p, sweep[p] + sweep[p + PERIOD / 2]);
      end
    end
    checks++;
    if (sweep[256] != 255) begin
      errors++;
      $display("FAIL peak_S256: got %0d expected 255", sweep[256]);
    end
    checks++;
    if (sweep[768] != 1) begin
      errors++;
      $display("FAIL trough_S768: got %0d expected 1", sweep[768]);
    end
  endtask

  task automatic test_fc10();
    int exp;
    int hist[0:519];
    int vmax;
    int vmin;
    int first_peak;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.freq_control = 10'd10;
    vmax = 0;
    vmin = 1000;
    first_peak = -1;
    for (int i = 0; i < 520; i++) begin
      run_cycle();
      exp = exp_q.pop_front();
      hist[i] = int'(bus.sine_out);
      if (hist[i] > vmax) vmax = hist[i];
      if (hist[i] < vmin) vmin = hist[i];
      if (hist[i] == 255 && first_peak < 0) first_peak = i;
      checks++;
      if (bus.sine_out !== 8'(exp)) begin
        errors++;
        $display("FAIL fc10[%0d]: got %0d expected %0d", i, bus.sine_out, exp);
      end
    end
    checks++;
    if (vmax != 255 || vmin != 1) begin
      errors++;
      $display("FAIL fc10_range: got max %0d min %0d expected 255/1", vmax, vmin);
    end
    checks++;
    if (first_peak != 25) begin
      errors++;
      $display("FAIL fc10_first_peak: got cycle %0d expected 25", first_peak);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hist[i + 512] != hist[i]) begin
        errors++;
        $display("FAIL fc10_period[%0d]: got %0d expected %0d", i, hist[i + 512], hist[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int exp;
    bus.freq_control = 10'd10;
    repeat (37) begin
      run_cycle();
      exp = exp_q.pop_front();
      checks++;
      if (bus.sine_out !== 8'(exp)) begin
        errors++;
        $display("FAIL pre_async: got %0d expected %0d", bus.sine_out, exp);
      end
    end
    // Assert reset between edges and observe before the next edge.
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.sine_out !== 8'd128) begin
      errors++;
      $display("FAIL async_out: got %0d expected 128", bus.sine_out);
    end
    checks++;
    if (dut.acc !== 10'd0) begin
      errors++;
      $display("FAIL async_acc: got %0d expected 0", dut.acc);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      run_cycle();
      exp = exp_q.pop_front();
      checks++;
      if (bus.sine_out !== 8'(exp) || (i == 0 && bus.sine_out !== 8'd128)) begin
        errors++;
        $display("FAIL post_async[%0d]: got %0d expected %0d", i, bus.sine_out, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp;
    int words[6];
    words = '{700, 1023, 512, 3, 0, 511};
    for (int i = 0; i < 64; i++) begin
      if (i < 6) bus.freq_control = 10'(words[i]);
      else       bus.freq_control = 10'($urandom_range(0, PERIOD - 1));
      run_cycle();
      exp = exp_q.pop_front();
      checks++;
      if (bus.sine_out !== 8'(exp)) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %0d expected %0d", i, bus.sine_out, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_freeze();
    test_quarter_step();
    test_golden_sweep();
    test_fc10();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_sine_wave_gen
`default_nettype wire
